// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode/funct constants, ALU op enum, control word and field helpers
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_SLL
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst_rd;
    logic    alu_src_imm;
    logic    mem_to_reg;
    logic    mem_write;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    logic    halt;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic [5:0] f_opcode(input logic [31:0] ins);
    return ins[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ins);
    return ins[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ins);
    return ins[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ins);
    return ins[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] ins);
    return ins[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] ins);
    return ins[5:0];
  endfunction

  function automatic logic [15:0] f_imm16(input logic [31:0] ins);
    return ins[15:0];
  endfunction

  function automatic logic [25:0] f_imm26(input logic [31:0] ins);
    return ins[25:0];
  endfunction

endpackage

// File: rtl/mips_sc_if.sv
// rtl/mips_sc_if.sv - memory load ports, run control and status of the single-cycle core
interface mips_sc_if;
  logic [31:0] IData_in;
  logic [31:0] IAddr_in;
  logic        icache_we;
  logic [31:0] DData_in;
  logic [31:0] DAddr_in;
  logic        dcache_we;
  logic        start;
  logic        processor_running;
  logic [31:0] current_pc;
  logic [31:0] current_instruction;

  modport master (
    output IData_in, IAddr_in, icache_we, DData_in, DAddr_in, dcache_we, start,
    input  processor_running, current_pc, current_instruction
  );

  modport slave (
    input  IData_in, IAddr_in, icache_we, DData_in, DAddr_in, dcache_we, start,
    output processor_running, current_pc, current_instruction
  );
endinterface

// File: rtl/mips_datapath.sv
// rtl/mips_datapath.sv - register file, data memory, ALU, writeback and next-PC selection
module mips_datapath
  import mips_pkg::*;
#(
  parameter int DMEM_DEPTH = 64,
  parameter int DAW        = $clog2(DMEM_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           commit,
  input  ctrl_t          ctrl,
  input  logic [4:0]     rs,
  input  logic [4:0]     rt,
  input  logic [4:0]     rd,
  input  logic [4:0]     shamt,
  input  logic [15:0]    imm16,
  input  logic [25:0]    imm26,
  input  logic [31:0]    pc,
  input  logic           dmem_we_ext,
  input  logic [DAW-1:0] dmem_addr_ext,
  input  logic [31:0]    dmem_data_ext,
  output logic [31:0]    next_pc
);
  logic [31:0] rs_val, rt_val, imm_sext, alu_b, alu_y, mem_rdata, wb_data;
  logic [31:0] pc_plus1;
  logic [4:0]  wr_addr;
  logic        taken;

  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign alu_b    = ctrl.alu_src_imm ? imm_sext : rt_val;
  assign wr_addr  = ctrl.reg_dst_rd ? rd : rt;
  assign wb_data  = ctrl.mem_to_reg ? mem_rdata : alu_y;

  mips_regfile reg_file (
    .clk     (clk),
    .rst     (rst),
    .we      (commit & ctrl.reg_write),
    .waddr   (wr_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  mips_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) D_cache (
    .clk       (clk),
    .we_core   (commit & ctrl.mem_write),
    .addr_core (alu_y[DAW-1:0]),
    .data_core (rt_val),
    .we_ext    (dmem_we_ext),
    .addr_ext  (dmem_addr_ext),
    .data_ext  (dmem_data_ext),
    .rdata     (mem_rdata)
  );

  always_comb begin
    alu_y = '0;
    case (ctrl.alu_op)
      ALU_ADD: alu_y = rs_val + alu_b;
      ALU_SUB: alu_y = rs_val - alu_b;
      ALU_AND: alu_y = rs_val & alu_b;
      ALU_OR:  alu_y = rs_val | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_SLL: alu_y = alu_b << shamt;
      default: alu_y = '0;
    endcase
  end

  assign pc_plus1 = pc + 32'd1;
  assign taken    = (ctrl.branch_eq & (rs_val == rt_val)) |
                    (ctrl.branch_ne & (rs_val != rt_val));

  always_comb begin
    next_pc = pc_plus1;
    if (ctrl.jump)      next_pc = {6'd0, imm26};
    else if (taken)     next_pc = pc_plus1 + imm_sext;
    else if (ctrl.halt) next_pc = pc;
  end
endmodule

// File: rtl/mips_dmem.sv
// rtl/mips_dmem.sv - word-addressed data memory, async read, core store plus external load port
module mips_dmem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_core,
  input  logic [AW-1:0] addr_core,
  input  logic [31:0]   data_core,
  input  logic          we_ext,
  input  logic [AW-1:0] addr_ext,
  input  logic [31:0]   data_ext,
  output logic [31:0]   rdata
);
  logic [31:0] regs [0:DEPTH-1];

  // External load is applied last so it overrides a store to the same word.
  always_ff @(posedge clk) begin
    if (we_core) regs[addr_core] <= data_core;
    if (we_ext)  regs[addr_ext]  <= data_ext;
  end

  assign rdata = regs[addr_core];
endmodule

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32x32 register file, two async reads, one sync write, $0 hardwired
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];
endmodule

// File: rtl/mips_sc_top.sv
// rtl/mips_sc_top.sv - single-cycle MIPS-subset core: PC, decode, run/halt control, instruction memory
// Optional HALT instruction (opcode 0x3F) enabled by defining MIPS_HALT_EN.
module mips_sc_top
  import mips_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input logic    clk,
  input logic    rst,
  mips_sc_if.slave bus
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0]    imem [0:IMEM_DEPTH-1];
  logic [IAW-1:0] pc;
  logic [31:0]    instr;
  logic [31:0]    next_pc;
  logic           halted;
  logic           running;
  logic           commit;
  ctrl_t          ctrl;

  always_ff @(posedge clk) begin
    if (bus.icache_we) imem[bus.IAddr_in[IAW-1:0]] <= bus.IData_in;
  end

  assign instr = imem[pc];

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (f_opcode(instr))
      OP_RTYPE: begin
        ctrl.reg_dst_rd = 1'b1;
        ctrl.reg_write  = 1'b1;
        case (f_funct(instr))
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          FN_SLL:  ctrl.alu_op = ALU_SLL;
          default: ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
      end
      OP_BEQ: ctrl.branch_eq = 1'b1;
      OP_BNE: ctrl.branch_ne = 1'b1;
      OP_J:   ctrl.jump      = 1'b1;
`ifdef MIPS_HALT_EN
      OP_HALT: ctrl.halt = 1'b1;
`endif
      default: ;
    endcase
  end

  assign running = bus.start & ~halted;
  // An edge seen while reset is low must not commit a store.
  assign commit  = running & rst;

`ifdef MIPS_HALT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halted <= 1'b0;
    else if (commit && ctrl.halt) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else if (commit) pc <= next_pc[IAW-1:0];
  end

  mips_datapath #(.DMEM_DEPTH(DMEM_DEPTH), .DAW(DAW)) datapath_inst (
    .clk           (clk),
    .rst           (rst),
    .commit        (commit),
    .ctrl          (ctrl),
    .rs            (f_rs(instr)),
    .rt            (f_rt(instr)),
    .rd            (f_rd(instr)),
    .shamt         (f_shamt(instr)),
    .imm16         (f_imm16(instr)),
    .imm26         (f_imm26(instr)),
    .pc            ({{(32-IAW){1'b0}}, pc}),
    .dmem_we_ext   (bus.dcache_we),
    .dmem_addr_ext (bus.DAddr_in[DAW-1:0]),
    .dmem_data_ext (bus.DData_in),
    .next_pc       (next_pc)
  );

  assign bus.processor_running   = running;
  assign bus.current_pc          = {{(32-IAW){1'b0}}, pc};
  assign bus.current_instruction = instr;

  logic unused_bits;
  assign unused_bits = ^{bus.IAddr_in[31:IAW], bus.DAddr_in[31:DAW], next_pc[31:IAW]};
endmodule

// File: tb/tb_mips_sc_top.sv
// tb/tb_mips_sc_top.sv - directed programs checked against an ISA-level model of the core
module tb_mips_sc_top;
  logic clk = 1'b0;
  logic rst;
  logic checking = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  mips_sc_if bus ();

  mips_sc_top #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ISA-level reference state
  logic [31:0] m_imem [0:63];
  logic [31:0] m_dmem [0:63];
  logic [31:0] m_reg  [0:31];
  logic [5:0]  m_pc;
  logic        m_halted;
  logic [31:0] prog   [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk or negedge rst) begin
    logic [31:0] ins, a, b, simm, res, ea;
    logic [5:0]  npc;
    logic [4:0]  dst;
    logic        wr;
    if (!rst) begin
      m_pc     <= '0;
      m_halted <= 1'b0;
      for (int r = 0; r < 32; r++) m_reg[r] <= '0;
    end else if (bus.start && !m_halted) begin
      ins  = m_imem[m_pc];
      a    = m_reg[ins[25:21]];
      b    = m_reg[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      ea   = a + simm;
      npc  = m_pc + 6'd1;
      wr   = 1'b0;
      dst  = ins[20:16];
      res  = '0;
      case (ins[31:26])
        6'h00: begin
          dst = ins[15:11];
          wr  = 1'b1;
          case (ins[5:0])
            6'h20: res = a + b;
            6'h22: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: res = b << ins[10:6];
            default: wr = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; res = a + simm; end
        6'h23: begin wr = 1'b1; res = m_dmem[ea[5:0]]; end
        6'h2B: m_dmem[ea[5:0]] <= b;
        6'h04: if (a == b) npc = m_pc + 6'd1 + simm[5:0];
        6'h05: if (a != b) npc = m_pc + 6'd1 + simm[5:0];
        6'h02: npc = ins[5:0];
`ifdef MIPS_HALT_EN
        6'h3F: begin m_halted <= 1'b1; npc = m_pc; end
`endif
        default: ;
      endcase
      if (wr && dst != 5'd0) m_reg[dst] <= res;
      m_pc <= npc;
    end
    if (bus.icache_we) m_imem[bus.IAddr_in[5:0]] <= bus.IData_in;
    if (bus.dcache_we) m_dmem[bus.DAddr_in[5:0]] <= bus.DData_in;
  end

  always @(negedge clk) begin
    if (checking && rst) begin
      chk("pc", bus.current_pc, {26'd0, m_pc});
      chk("running", {31'd0, bus.processor_running}, {31'd0, bus.start & ~m_halted});
      chk("instr", bus.current_instruction, m_imem[m_pc]);
    end
  end

  function automatic logic [31:0] rt_(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] it_(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] jt_(input int adr);
    return {6'h02, 26'(adr)};
  endfunction

  function automatic logic [31:0] rf(input int i);
    return dut.datapath_inst.reg_file.regs[i];
  endfunction

  function automatic logic [31:0] dm(input int i);
    return dut.datapath_inst.D_cache.regs[i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = '0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) begin
      bus.icache_we = 1'b1;
      bus.IAddr_in  = 32'(i);
      bus.IData_in  = prog[i];
      tick();
    end
    bus.icache_we = 1'b0;
  endtask

  task automatic wr_dmem(input int adr, input logic [31:0] d);
    bus.dcache_we = 1'b1;
    bus.DAddr_in  = 32'(adr);
    bus.DData_in  = d;
    tick();
    bus.dcache_we = 1'b0;
  endtask

  task automatic load_array();
    wr_dmem(0, 32'd42);
    wr_dmem(1, 32'd23);
    wr_dmem(2, 32'd16);
    wr_dmem(3, 32'd8);
    wr_dmem(4, 32'd156);
  endtask

  task automatic run(input int n);
    bus.start = 1'b1;
    repeat (n) tick();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic check_arch(input string tag);
    for (int i = 0; i < 32; i++) chk($sformatf("%s reg%0d", tag, i), rf(i), m_reg[i]);
    for (int i = 0; i < 64; i++) chk($sformatf("%s dmem%0d", tag, i), dm(i), m_dmem[i]);
  endtask

  initial begin
    bus.IData_in = '0; bus.IAddr_in = '0; bus.icache_we = 1'b0;
    bus.DData_in = '0; bus.DAddr_in = '0; bus.dcache_we = 1'b0;
    bus.start = 1'b0;
    rst = 1'b1;
    #3 rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.icache_we = 1'b1; bus.dcache_we = 1'b1;
      bus.IAddr_in = 32'(i); bus.DAddr_in = 32'(i);
      bus.IData_in = '0;     bus.DData_in = '0;
      tick();
    end
    bus.icache_we = 1'b0; bus.dcache_we = 1'b0;
    rst = 1'b1;
    tick();
    checking = 1'b1;
    chk("reset pc", bus.current_pc, 32'd0);
    chk("reset running", {31'd0, bus.processor_running}, 32'd0);
    chk("reset reg8", rf(8), 32'd0);

    // addi then add
    clear_prog();
    prog[0] = it_(8, 0, 8, 5);
    prog[1] = rt_(8, 8, 9, 0, 'h20);
    load_prog();
    run(2);
    chk("t1 reg9", rf(9), 32'd10);
    chk("t1 pc", bus.current_pc, 32'd2);
    check_arch("t1");

    // ALU ops, $0 writes, unknown encodings
    do_reset();
    clear_prog();
    prog[0]  = it_(8, 0, 0, 7);
    prog[1]  = it_(8, 0, 9, 3);
    prog[2]  = rt_(0, 9, 11, 0, 'h00);
    prog[3]  = it_(8, 0, 10, -1);
    prog[4]  = rt_(10, 0, 25, 0, 'h2a);
    prog[5]  = it_(8, 0, 12, 12);
    prog[6]  = it_(8, 0, 13, 10);
    prog[7]  = rt_(12, 13, 14, 0, 'h22);
    prog[8]  = rt_(12, 13, 15, 0, 'h24);
    prog[9]  = rt_(12, 13, 16, 0, 'h25);
    prog[10] = rt_(0, 12, 17, 4, 'h00);
    prog[11] = rt_(0, 10, 18, 0, 'h2a);
    prog[12] = rt_(12, 13, 19, 0, 'h27);
    prog[13] = 32'hFC00_0000;
    prog[14] = rt_(10, 10, 20, 0, 'h20);
    load_prog();
    run(15);
    chk("t2 reg0", rf(0), 32'd0);
    chk("t2 reg11 sll0", rf(11), 32'd3);
    chk("t2 reg25 slt", rf(25), 32'd1);
    chk("t2 reg14 sub", rf(14), 32'd2);
    chk("t2 reg15 and", rf(15), 32'd8);
    chk("t2 reg16 or", rf(16), 32'd14);
    chk("t2 reg17 sll4", rf(17), 32'd192);
    chk("t2 reg18 slt0", rf(18), 32'd0);
    chk("t2 reg19 badfn", rf(19), 32'd0);
`ifdef MIPS_HALT_EN
    chk("t2 reg20 halted", rf(20), 32'd0);
    chk("t2 pc halted", bus.current_pc, 32'd13);
    chk("t2 running halted", {31'd0, bus.processor_running}, 32'd0);
`else
    chk("t2 reg20 add", rf(20), 32'hFFFF_FFFE);
    chk("t2 pc", bus.current_pc, 32'd15);
`endif
    check_arch("t2");

    // branches and jump
    do_reset();
    clear_prog();
    prog[0]  = it_(8, 0, 8, 1);
    prog[1]  = it_(8, 0, 9, 1);
    prog[2]  = it_(4, 9, 8, 3);
    prog[6]  = it_(5, 9, 8, 5);
    prog[7]  = it_(5, 9, 0, 11);
    prog[19] = it_(4, 0, 0, -3);
    prog[17] = jt_(6);
    load_prog();
    run(3);
    chk("beq taken pc", bus.current_pc, 32'd6);
    run(1);
    chk("bne equal pc", bus.current_pc, 32'd7);
    run(1);
    chk("bne taken pc", bus.current_pc, 32'd19);
    run(1);
    chk("beq back pc", bus.current_pc, 32'd17);
    run(1);
    chk("j pc", bus.current_pc, 32'd6);

    // PC wraps modulo depth
    do_reset();
    clear_prog();
    prog[0]  = it_(4, 0, 0, -2);
    prog[63] = it_(8, 5, 5, 9);
    load_prog();
    run(2);
    chk("wrap pc0", bus.current_pc, 32'd0);
    chk("wrap reg5", rf(5), 32'd9);
    run(1);
    chk("wrap pc63", bus.current_pc, 32'd63);

    // loads, stores, external write priority
    do_reset();
    load_array();
    clear_prog();
    prog[0] = it_(8, 0, 11, 1);
    prog[1] = it_('h23, 11, 11, 0);
    prog[2] = it_(8, 0, 12, 99);
    prog[3] = it_('h2b, 0, 12, 2);
    prog[4] = it_(8, 0, 13, 5);
    prog[5] = it_('h23, 13, 14, -1);
    prog[6] = it_('h2b, 0, 12, 3);
    load_prog();
    run(6);
    chk("lw reg11", rf(11), 32'd23);
    chk("lw neg off reg14", rf(14), 32'd156);
    chk("sw dmem2", dm(2), 32'd99);
    chk("sw dmem0", dm(0), 32'd42);
    chk("sw dmem1", dm(1), 32'd23);
    chk("sw dmem3", dm(3), 32'd8);
    chk("sw dmem4", dm(4), 32'd156);
    bus.start = 1'b1; bus.dcache_we = 1'b1; bus.DAddr_in = 32'd3; bus.DData_in = 32'd777;
    tick();
    bus.start = 1'b0; bus.dcache_we = 1'b0;
    chk("ext wins dmem3", dm(3), 32'd777);
    check_arch("mem");

    // insertion sort
    do_reset();
    load_array();
    clear_prog();
    prog[0]  = it_(8, 0, 9, 5);
    prog[1]  = it_(8, 0, 8, 1);
    prog[2]  = it_(4, 8, 9, 13);
    prog[3]  = it_('h23, 8, 10, 0);
    prog[4]  = it_(8, 8, 11, -1);
    prog[5]  = rt_(11, 0, 12, 0, 'h2a);
    prog[6]  = it_(5, 12, 0, 6);
    prog[7]  = it_('h23, 11, 13, 0);
    prog[8]  = rt_(10, 13, 12, 0, 'h2a);
    prog[9]  = it_(4, 12, 0, 3);
    prog[10] = it_('h2b, 11, 13, 1);
    prog[11] = it_(8, 11, 11, -1);
    prog[12] = jt_(5);
    prog[13] = it_('h2b, 11, 10, 1);
    prog[14] = it_(8, 8, 8, 1);
    prog[15] = jt_(2);
    prog[16] = jt_(16);
    load_prog();
    run(400);
    chk("sort d0", dm(0), 32'd8);
    chk("sort d1", dm(1), 32'd16);
    chk("sort d2", dm(2), 32'd23);
    chk("sort d3", dm(3), 32'd42);
    chk("sort d4", dm(4), 32'd156);
    chk("sort reg8", rf(8), 32'd5);
    chk("sort reg9", rf(9), 32'd5);
    chk("sort pc", bus.current_pc, 32'd16);
    check_arch("sort");

    // freeze mid-run, resume, then reset mid-run
    do_reset();
    load_array();
    run(20);
    repeat (10) tick();
    check_arch("frozen");
    run(400);
    chk("resume d0", dm(0), 32'd8);
    chk("resume d4", dm(4), 32'd156);
    chk("resume reg8", rf(8), 32'd5);
    do_reset();
    bus.start = 1'b1;
    repeat (7) tick();
    rst = 1'b0;
    #1;
    chk("midrst pc", bus.current_pc, 32'd0);
    chk("midrst reg9", rf(9), 32'd0);
    chk("midrst reg8", rf(8), 32'd0);
    tick();
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst keep d0", dm(0), 32'd8);
    chk("midrst keep d2", dm(2), 32'd23);
    chk("midrst keep d4", dm(4), 32'd156);
    check_arch("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
